bf16_pcpi_dispatcher: RTL and testbench
=======================================

// Module: bf16_pcpi_dispatcher
// PURPOSE
//  Initiator for the bf16 operation units. Decodes a PicoRV32 PCPI custom-0 instruction and
//  splits rs1/rs2 into four bf16 operands. Issues them over the STB/BUSY input handshake,
//  then acts as output module for the result. Returns the result to the core via pcpi_rd.
// PARAMETERS
//  FUNCT7          7'b0100000  insn[31:25] value selecting this unit
//  FUNCT3          3'b000      insn[14:12] value selecting this unit
//  TIMEOUT_CYCLES  255         watchdog limit (cycles), used only with BF16_DISP_TIMEOUT_EN
// PORTS
//  clk             in   1   clock, all logic on posedge
//  rst             in   1   synchronous reset, active-low (rst==0 resets)
//  pcpi_valid      in   1   core presents instruction
//  pcpi_insn       in   32  instruction word
//  pcpi_rs1        in   32  {a,b} operands
//  pcpi_rs2        in   32  {c,d} operands
//  pcpi_wr         out  1   write rd, pulses with pcpi_ready
//  pcpi_rd         out  32  {16'h0000, result}
//  pcpi_wait       out  1   unit busy with accepted instruction
//  pcpi_ready      out  1   one-cycle completion pulse
//  op_a/b/c/d      out  16  each: operands to op unit
//  op_input_STB    out  1   operands valid
//  op_BUSY         in   1   op unit has captured/is busy
//  op_result       in   16  bf16 result from op unit
//  op_output_STB   in   1   result valid
//  out_busy        out  1   this block's output_module_BUSY toward op unit
//  timeout_err     out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset (rst==0): state=IDLE; pcpi_wr/pcpi_ready/pcpi_wait/op_input_STB/timeout_err=0.
//   Also out_busy=1, pcpi_rd=0, op_a..op_d=0. Reset aborts any operation immediately.
//  Match: pcpi_valid && insn[6:0]==7'b0001011 && insn[31:25]==FUNCT7 && insn[14:12]==FUNCT3.
//  Operand map: op_a=rs1[31:16], op_b=rs1[15:0], op_c=rs2[31:16], op_d=rs2[15:0].
//  Operands are registered on accept and held stable until state returns to IDLE.
//  FSM:
//   IDLE: on match, latch operands, op_input_STB<=1, pcpi_wait<=1 -> WAIT_ACK. Non-match: stay, outputs idle.
//   WAIT_ACK: when op_input_STB && op_BUSY: op_input_STB<=0, out_busy<=0 -> WAIT_RESULT.
//   WAIT_RESULT: first cycle op_output_STB && !out_busy: capture op_result -> DRAIN.
//   DRAIN: out_busy held 0 until op_output_STB seen 0, then out_busy<=1, pcpi_wait<=0,
//    pcpi_ready<=1, pcpi_wr<=1, pcpi_rd<={16'h0,result} -> RESPOND.
//    Result is captured exactly once even if STB stays high many cycles.
//   RESPOND: pcpi_ready<=0, pcpi_wr<=0 -> RELEASE.
//   RELEASE: wait pcpi_valid==0 -> IDLE; prevents re-issue of the completed instruction.
//  Min latency match->pcpi_ready = op unit latency + 4 cycles. No pipelining; one op in flight.
//  out_busy low only in WAIT_RESULT/DRAIN. op_input_STB high only in WAIT_ACK.
//  pcpi_rd holds last result until next completion.
// CONFIGURATION
//  BF16_DISP_TIMEOUT_EN defined:
//   - 8-bit counter clears on accept and counts in WAIT_ACK/WAIT_RESULT/DRAIN.
//   - When it reaches TIMEOUT_CYCLES: op_input_STB<=0, out_busy<=1, timeout_err<=1 (sticky until reset).
//   - Then complete via RESPOND with pcpi_rd=32'hFFFF_FFFF.
//  Undefined: no counter, waits indefinitely; timeout_err tied 0.
// TESTING
//  Reset: rst=0 two cycles -> out_busy=1, all other outputs 0, state IDLE.
//  Normal op, model unit: rs1=32'h3F80_4000, rs2=32'h4040_4080 (1/2 + 3/4).
//   -> op_a..d=3F80/4000/4040/4080; one-cycle pcpi_ready+pcpi_wr; pcpi_rd=32'h0000_3FA0.
//  Non-match: insn funct7=7'b0000001, pcpi_valid=1 for 20 cycles -> pcpi_wait=0, op_input_STB never 1.
//  Slow output: model holds op_output_STB 5 cycles -> single capture; out_busy=0 until STB falls.
//   Then pcpi_ready exactly once.
//  Held valid: pcpi_valid kept 3 cycles after ready -> no second op_input_STB.
//  Timeout (macro on, TIMEOUT_CYCLES=16, op_BUSY stuck 0):
//   -> ready at count 16, pcpi_rd=FFFF_FFFF, timeout_err=1.
//  Reset mid-op: rst=0 in WAIT_RESULT -> next cycle IDLE, out_busy=1, pcpi_wait=0, no ready pulse.

Source files
------------

// File: rtl/bf16_pcpi_dispatcher.sv
// PCPI custom-0 front end for the bf16 op units: splits rs1/rs2 into four operands and returns the result.
// Optional watchdog enabled by defining BF16_DISP_TIMEOUT_EN.
module bf16_pcpi_dispatcher #(
  parameter logic [6:0]  FUNCT7         = 7'b0100000,
  parameter logic [2:0]  FUNCT3         = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [15:0] op_c,
  output logic [15:0] op_d,
  output logic        op_input_STB,
  input  logic        op_BUSY,
  input  logic [15:0] op_result,
  input  logic        op_output_STB,
  output logic        out_busy,
  output logic        timeout_err
);

  localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE, WAIT_ACK, WAIT_RESULT, DRAIN, RESPOND, RELEASE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [15:0] result_q, result_d;
  logic [31:0] rd_q, rd_d;
  logic        stb_q, stb_d;
  logic        pwait_q, pwait_d;
  logic        ready_q, ready_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        match_c;

  assign match_c = pcpi_valid && (pcpi_insn[6:0] == OPC_CUSTOM0) &&
                   (pcpi_insn[31:25] == FUNCT7) && (pcpi_insn[14:12] == FUNCT3);

`ifdef BF16_DISP_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             unused_insn;

  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  assign timeout_err = err_q;
`else
  logic unused_insn;

  // Watchdog limit only matters when the watchdog is built in.
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7], (TIMEOUT_CYCLES != 0)};
  assign timeout_err = 1'b0;
`endif

  assign op_a         = a_q;
  assign op_b         = b_q;
  assign op_c         = c_q;
  assign op_d         = d_q;
  assign op_input_STB = stb_q;
  assign out_busy     = busy_q;
  assign pcpi_wait    = pwait_q;
  assign pcpi_ready   = ready_q;
  assign pcpi_wr      = wr_q;
  assign pcpi_rd      = rd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      result_q <= '0;
      rd_q     <= '0;
      stb_q    <= 1'b0;
      pwait_q  <= 1'b0;
      ready_q  <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b1;
`ifdef BF16_DISP_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      stb_q    <= stb_d;
      pwait_q  <= pwait_d;
      ready_q  <= ready_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
`ifdef BF16_DISP_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    result_d = result_q;
    rd_d     = rd_q;
    stb_d    = stb_q;
    pwait_d  = pwait_q;
    ready_d  = ready_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
`ifdef BF16_DISP_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (match_c) begin
          a_d     = pcpi_rs1[31:16];
          b_d     = pcpi_rs1[15:0];
          c_d     = pcpi_rs2[31:16];
          d_d     = pcpi_rs2[15:0];
          stb_d   = 1'b1;
          pwait_d = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (stb_q && op_BUSY) begin
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (op_output_STB && !busy_q) begin
          result_d = op_result;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        // Keep accepting until the unit drops its strobe so a long strobe is not re-captured.
        if (!op_output_STB) begin
          busy_d  = 1'b1;
          pwait_d = 1'b0;
          ready_d = 1'b1;
          wr_d    = 1'b1;
          rd_d    = {16'h0000, result_q};
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        ready_d = 1'b0;
        wr_d    = 1'b0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!pcpi_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef BF16_DISP_TIMEOUT_EN
    // Watchdog overrides the normal flow and completes with an all-ones result.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_ACK) || (state_q == WAIT_RESULT) || (state_q == DRAIN)) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
        stb_d   = 1'b0;
        busy_d  = 1'b1;
        err_d   = 1'b1;
        pwait_d = 1'b0;
        ready_d = 1'b1;
        wr_d    = 1'b1;
        rd_d    = 32'hFFFF_FFFF;
        state_d = RESPOND;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_bf16_pcpi_dispatcher.sv
// Scoreboard bench for bf16_pcpi_dispatcher with a behavioural bf16 op unit on the STB/BUSY handshake.
module tb_bf16_pcpi_dispatcher;

`ifdef BF16_DISP_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  localparam logic [31:0] INSN_OK  = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
  localparam logic [31:0] INSN_F7  = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0001011};
  localparam logic [31:0] INSN_F3  = {7'b0100000, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0001011};
  localparam logic [31:0] INSN_OPC = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0101011};

  logic        clk, rst;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic [15:0] op_a, op_b, op_c, op_d;
  logic        op_input_STB, op_BUSY, op_output_STB, out_busy, timeout_err;
  logic [15:0] op_result;

  bf16_pcpi_dispatcher #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .op_input_STB(op_input_STB), .op_BUSY(op_BUSY), .op_result(op_result),
    .op_output_STB(op_output_STB), .out_busy(out_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_ops[$];
  logic [31:0] exp_rd[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        stb_prev = 1'b0;
  logic [63:0] cur_ops = '0;
  bit          unit_en = 1'b1;
  int          m_lat = 2;
  int          m_hold = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Op unit computes a/b + c/d; known operand sets only, anything else returns a marker.
  function automatic logic [15:0] unit_calc(input logic [63:0] ops);
    case (ops)
      64'h3F80_4000_4040_4080: unit_calc = 16'h3FA0;
      64'h4000_4000_3F80_4000: unit_calc = 16'h3FC0;
      64'h0000_3F80_3F80_3F80: unit_calc = 16'h3F80;
      64'h4080_4000_4100_4080: unit_calc = 16'h4080;
      default:                 unit_calc = 16'hDEAD;
    endcase
  endfunction

  // Behavioural op unit, driven on negedge; aborts if reset is seen.
  initial begin
    logic [63:0] cap;
    bit alive;
    int g;
    op_BUSY = 1'b0; op_output_STB = 1'b0; op_result = '0;
    forever begin
      @(negedge clk);
      if (unit_en && rst && op_input_STB) begin
        cap = {op_a, op_b, op_c, op_d};
        op_BUSY = 1'b1;
        alive = 1'b1;
        g = 0;
        while (alive && (op_input_STB || out_busy) && g < 100) begin
          @(negedge clk); g++;
          if (!rst) alive = 1'b0;
        end
        for (int i = 0; i < m_lat && alive; i++) begin
          @(negedge clk);
          if (!rst) alive = 1'b0;
        end
        if (alive) begin
          op_result = unit_calc(cap);
          op_output_STB = 1'b1;
        end
        for (int i = 1; i < m_hold && alive; i++) begin
          @(negedge clk);
          if (!rst) alive = 1'b0;
          op_result = 16'h7FC0;
        end
        @(negedge clk);
        op_output_STB = 1'b0; op_BUSY = 1'b0; op_result = '0;
      end
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT issues operands or completes.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        if (op_input_STB && !stb_prev) begin
          if (exp_ops.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_issue: got ops %h expected no issue", {op_a, op_b, op_c, op_d});
          end else begin
            cur_ops = exp_ops.pop_front();
            check("issue_ops", {op_a, op_b, op_c, op_d}, cur_ops);
          end
        end
        if (op_output_STB) check("out_busy_while_out_stb", 64'(out_busy), 64'd0);
        if (pcpi_ready) begin
          if (exp_rd.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ready: got rd %h expected no completion", pcpi_rd);
          end else begin
            check("pcpi_rd", 64'(pcpi_rd), 64'(exp_rd.pop_front()));
            check("pcpi_wr", 64'(pcpi_wr), 64'd1);
            check("ops_held", {op_a, op_b, op_c, op_d}, cur_ops);
          end
        end
      end
      stb_prev = op_input_STB;
    end
  end

  task automatic issue(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] exp,
                       input int lat, input int hold, input int extra);
    bit got;
    m_lat = lat; m_hold = hold;
    exp_ops.push_back({rs1, rs2});
    exp_rd.push_back(exp);
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = INSN_OK; pcpi_rs1 = rs1; pcpi_rs2 = rs2;
    @(posedge clk); #1;
    check("wait_on_accept", 64'(pcpi_wait), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (pcpi_ready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got no pcpi_ready expected one within 300 cycles");
    end
    repeat (extra) @(negedge clk);
    @(negedge clk);
    pcpi_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_op", {62'd0, out_busy, pcpi_wait}, 64'b10);
  endtask

  initial begin
    rst = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_busy", 64'(out_busy), 64'd1);
    check("rst_ctrl", {59'd0, pcpi_wr, pcpi_ready, pcpi_wait, op_input_STB, timeout_err}, 64'd0);
    check("rst_rd", 64'(pcpi_rd), 64'd0);
    check("rst_ops", {op_a, op_b, op_c, op_d}, 64'd0);
    @(negedge clk); rst = 1'b1;

    issue(32'h3F80_4000, 32'h4040_4080, 32'h0000_3FA0, 2, 1, 0);
    issue(32'h4000_4000, 32'h3F80_4000, 32'h0000_3FC0, 0, 1, 0);
    issue(32'h0000_3F80, 32'h3F80_3F80, 32'h0000_3F80, 1, 5, 0);
    issue(32'h4080_4000, 32'h4100_4080, 32'h0000_4080, 3, 1, 3);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pcpi_valid = 1'b1; pcpi_rs1 = 32'h3F80_4000; pcpi_rs2 = 32'h4040_4080;
      pcpi_insn = (k == 0) ? INSN_F7 : ((k == 1) ? INSN_F3 : INSN_OPC);
      repeat (20) @(posedge clk);
      #1;
      check("nomatch_wait", 64'(pcpi_wait), 64'd0);
      @(negedge clk); pcpi_valid = 1'b0;
    end
    check("rd_holds_last", 64'(pcpi_rd), 64'h0000_4080);

    // Reset while the op unit is computing.
    begin
      bit seen;
      m_lat = 10; m_hold = 1;
      exp_ops.push_back(64'h3F80_4000_4040_4080);
      @(negedge clk);
      pcpi_valid = 1'b1; pcpi_insn = INSN_OK; pcpi_rs1 = 32'h3F80_4000; pcpi_rs2 = 32'h4040_4080;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (!out_busy) seen = 1'b1;
      end
      check("midop_reached_wait_result", 64'(seen), 64'd1);
      #1;
      rst = 1'b0; pcpi_valid = 1'b0;
      @(posedge clk); #1;
      check("midop_rst_out_busy", 64'(out_busy), 64'd1);
      check("midop_rst_ctrl", {61'd0, pcpi_wait, pcpi_ready, op_input_STB}, 64'd0);
      check("midop_rst_rd", 64'(pcpi_rd), 64'd0);
      @(negedge clk); rst = 1'b1;
      repeat (20) @(posedge clk);
    end

    issue(32'h3F80_4000, 32'h4040_4080, 32'h0000_3FA0, 1, 2, 0);

`ifdef BF16_DISP_TIMEOUT_EN
    unit_en = 1'b0;
    issue(32'h4000_4000, 32'h3F80_4000, 32'hFFFF_FFFF, 0, 1, 0);
    check("timeout_err_set", 64'(timeout_err), 64'd1);
    unit_en = 1'b1;
`else
    check("timeout_err_tied", 64'(timeout_err), 64'd0);
`endif

    check("scoreboard_drained", 64'(exp_ops.size() + exp_rd.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
